fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer for the asynchronous FIFO; runs entirely in the FIFO read clock domain.
- Pops bytes from the FIFO read port and packs LANES consecutive bytes into one wide word, little-endian.
- Presents each word downstream on a valid/ready handshake.
- A flush request emits a partially filled word with its byte count, so trailing bytes are never stranded.

Parameters:
- DSIZE, 8, FIFO data width in bits.
- LANES, 4, bytes per output word; must be >= 2.
- CNT_W, $clog2(LANES)+1, width of out_bytes (3 at defaults).
- TIMEOUT_CYC, 16, idle cycles before auto-flush; used only with PACK_TIMEOUT_EN.

Ports:
- rclk  in  1  read-domain clock; all state updates on the rising edge.
- rrst_n  in  1  asynchronous active-low reset.
- rdata  in  DSIZE  FIFO head entry; valid whenever rempty=0.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  pop request; the head is consumed at the rclk edge where rinc=1 and rempty=0.
- flush  in  1  single-cycle request to emit the partial word.
- out_data  out  DSIZE*LANES  packed word; the first byte popped sits in bits [DSIZE-1:0].
- out_bytes  out  CNT_W  number of valid bytes in out_data, 1..LANES.
- out_valid  out  1  out_data and out_bytes are valid.
- out_ready  in  1  downstream accepts the word.
- word_cnt  out  16  count of words transferred; wraps from 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync-safe deassert by the driver):
  - out_valid=0, out_data=0, out_bytes=0, word_cnt=0.
  - Internal byte count=0, state=FILL.
  - rinc forced 0 while rrst_n=0.
- States: FILL (accumulating bytes) and HOLD (word pending downstream).
- FILL:
  - rinc = !rempty, combinational.
  - On a pop, rdata is written into lane[count] and count increments.
  - When a pop makes count==LANES: at that same edge out_data is loaded with all lanes, out_bytes=LANES, out_valid=1, count=0, state goes to HOLD.
  - Latency: the LANES-th pop edge and out_valid rising are the same edge.
- Flush (sampled only in FILL):
  - flush=1, no pop, count>0: emit the partial word; out_bytes=count, unused lanes zero; go to HOLD.
  - flush=1 together with a pop: the popped byte is included. out_bytes=count+1, or a normal full word if that reaches LANES.
  - flush=1, count==0, no pop: ignored.
  - flush in HOLD: ignored, not queued.
- HOLD:
  - rinc=0.
  - out_data and out_bytes are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready at an edge: out_valid=0, word_cnt+1, state goes to FILL. Pops resume the following cycle.
  - Sustained throughput: one word per LANES+1 cycles.
- Lane registers are cleared when a word is emitted, so partial words never carry stale bytes.
- rempty toggling mid-word: packing pauses and resumes without loss; byte order is preserved.
- Reset mid-operation: partial bytes and any pending word are discarded, with no output pulse.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro: PACK_TIMEOUT_EN.
- Defined:
  - An idle counter runs in FILL while count>0 and no pop occurs.
  - When it reaches TIMEOUT_CYC, it behaves exactly as a flush on that edge.
  - The counter clears on any pop, on any emission, on reset, and whenever count==0.
- Undefined: no idle counter; partial words leave only via explicit flush; TIMEOUT_CYC is unused.

Test Plan:
- FIFO preloaded with 0x01..0x08, out_ready=1:
  - First word is out_data=0x04030201 with out_bytes=4.
  - Second word is 0x08070605.
  - word_cnt=2.
  - rinc low during each HOLD cycle.
- Bytes 0x11, 0x12 popped, then FIFO empty and flush pulsed:
  - out_data=0x00001211, out_bytes=2.
  - A later flush with count=0 produces no output.
- Full word pending with out_ready=0 for 10 cycles:
  - out_valid and out_data stable.
  - rinc=0 throughout, FIFO contents untouched.
  - On out_ready=1 the word transfers once and word_cnt increments by 1.
- Flush asserted on the same edge as the 3rd pop of 0xA1, 0xA2, 0xA3: out_data=0x00A3A2A1, out_bytes=3.
- rrst_n pulsed low after 2 bytes are packed:
  - All outputs return to 0 asynchronously.
  - Next 4 bytes 0x21..0x24 yield 0x24232221.
- With PACK_TIMEOUT_EN and TIMEOUT_CYC=16, one byte 0x5A then FIFO empty: after 16 idle cycles out_data=0x0000005A and out_bytes=1.
- Without PACK_TIMEOUT_EN, same stimulus: no output occurs.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer for the async FIFO, entirely in the rclk domain.
//   Pops bytes from the FIFO head and packs LANES consecutive bytes into
//   one little-endian word. The word is offered downstream on valid/ready.
//   A flush emits a partially filled word together with its byte count.
//
//   Optional macro PACK_TIMEOUT_EN: when defined, an idle counter
//   auto-flushes a partial word after TIMEOUT_CYC cycles without a pop.
//
// Ports
//   rclk, rrst_n  read clock, asynchronous active-low reset
//   rdata, rempty FIFO head entry and empty flag
//   rinc          pop request (head consumed when rinc=1 and rempty=0)
//   flush         single-cycle request to emit the partial word
//   out_data      packed word, first byte popped in bits [DSIZE-1:0]
//   out_bytes     valid byte count in out_data (1..LANES)
//   out_valid     out_data/out_bytes valid
//   out_ready     downstream accepts the word
//   word_cnt      words transferred, wraps at 16 bits
module fifo_rd_packer #(
  parameter int DSIZE       = 8,
  parameter int LANES       = 4,
  parameter int CNT_W       = $clog2(LANES) + 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*LANES-1:0] out_data,
  output logic [CNT_W-1:0]       out_bytes,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            word_cnt
);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                      state_q, state_d;
  logic [LANES-1:0][DSIZE-1:0] lane_q, lane_d, lane_n;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_n;
  logic [DSIZE*LANES-1:0]      data_q, data_d;
  logic [CNT_W-1:0]            bytes_q, bytes_d;
  logic                        valid_q, valid_d;
  logic [15:0]                 wcnt_q, wcnt_d;
  logic                        pop;
  logic                        emit;
  logic                        timeout_hit;

  // Pops only while accumulating; held off during reset regardless of state.
  assign pop  = rrst_n && (state_q == FILL) && !rempty;
  assign rinc = pop;

`ifdef PACK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Fires on the TIMEOUT_CYC-th consecutive idle edge with bytes pending.
  assign timeout_hit = (state_q == FILL) && !pop && (cnt_q != '0) &&
                       (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_d = '0;
    if ((state_q == FILL) && !pop && (cnt_q != '0) && !emit)
      idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`else
  // No idle counter in this build; TIMEOUT_CYC has no effect.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    bytes_d = bytes_q;
    valid_d = valid_q;
    wcnt_d  = wcnt_q;
    emit    = 1'b0;

    // Lanes and count as they would look after this edge's pop, so a flush
    // or a completing pop can emit the byte being consumed right now.
    lane_n = lane_q;
    cnt_n  = cnt_q;
    if (pop) begin
      for (int unsigned i = 0; i < LANES; i++)
        if (cnt_q == CNT_W'(i)) lane_n[i] = rdata;
      cnt_n = cnt_q + 1'b1;
    end

    case (state_q)
      FILL: begin
        emit = (pop && (cnt_n == CNT_W'(LANES))) ||
               ((flush || timeout_hit) && (cnt_n != '0));
        if (emit) begin
          data_d  = lane_n;
          bytes_d = cnt_n;
          valid_d = 1'b1;
          cnt_d   = '0;
          lane_d  = '0;
          state_d = HOLD;
        end else begin
          lane_d = lane_n;
          cnt_d  = cnt_n;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          wcnt_d  = wcnt_q + 16'd1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= FILL;
      lane_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      bytes_q <= '0;
      valid_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      bytes_q <= bytes_d;
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_bytes = bytes_q;
  assign out_valid = valid_q;
  assign word_cnt  = wcnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  localparam int DSIZE       = 8;
  localparam int LANES       = 4;
  localparam int CNT_W       = 3;
  localparam int TIMEOUT_CYC = 16;

  logic                   rclk;
  logic                   rrst_n;
  logic [DSIZE-1:0]       rdata;
  logic                   rempty;
  logic                   rinc;
  logic                   flush;
  logic [DSIZE*LANES-1:0] out_data;
  logic [CNT_W-1:0]       out_bytes;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            word_cnt;

  fifo_rd_packer #(
    .DSIZE      (DSIZE),
    .LANES      (LANES),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .flush    (flush),
    .out_data (out_data),
    .out_bytes(out_bytes),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .word_cnt (word_cnt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
  } word_t;

  // Reference: the FIFO contents, and the words the stream must produce.
  logic [7:0] fifo_q[$];
  word_t      exp_q[$];
  int         exp_wc;
  int         n_tests;
  int         n_fail;

  logic        stall_prev;
  logic [31:0] prev_data;
  logic [2:0]  prev_bytes;

  // Random-phase packing model: bytes accumulate little-endian.
  logic [31:0] pend_word;
  int          pend_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [2:0] b);
    word_t w;
    w.d = d;
    w.b = b;
    exp_q.push_back(w);
    exp_wc++;
  endtask

  // One clock: present FIFO head at negedge, observe, then consume on the edge.
  task automatic cyc();
    logic  pop, xfer;
    word_t w;
    @(negedge rclk);
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
    #1;
    pop  = rinc && !rempty;
    xfer = out_valid && out_ready;
    if (out_valid) check("rinc_in_hold", rinc, 0);
    if (stall_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
      check("stall_bytes", out_bytes, prev_bytes);
    end
    if (xfer) begin
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word_data", out_data, w.d);
        check("word_bytes", out_bytes, w.b);
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
    prev_bytes = out_bytes;
    @(posedge rclk);
    #1;
    if (pop) void'(fifo_q.pop_front());
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < bound) begin
      cyc();
      n++;
    end
    check({tag, "_drained"}, exp_q.size() + fifo_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_wc = 0;
    stall_prev = 1'b0; prev_data = '0; prev_bytes = '0;
    rrst_n = 1'b0; rdata = '0; rempty = 1'b1; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge rclk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_bytes", out_bytes, 0);
    check("rst_wcnt", word_cnt, 0);
    check("rst_rinc", rinc, 0);
    rrst_n = 1'b1;

    // Two full words from a preloaded FIFO
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    push_exp(32'h04030201, 3'd4);
    push_exp(32'h08070605, 3'd4);
    drain("full_words", 40);
    check("full_wcnt", word_cnt, 2);

    // Partial word via flush, then a flush with nothing pending
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h12);
    drain("partial_fill", 10);
    repeat (2) cyc();
    check("partial_no_early", out_valid, 0);
    push_exp(32'h00001211, 3'd2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_valid", out_valid, 1);
    check("flush_data", out_data, 32'h00001211);
    check("flush_bytes", out_bytes, 2);
    drain("flush", 10);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (4) cyc();
    check("empty_flush_ignored", out_valid, 0);
    check("empty_flush_wcnt", word_cnt, 3);

    // Backpressure: word held for 10 cycles, FIFO untouched
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h31 + 8'(i));
    push_exp(32'h34333231, 3'd4);
    push_exp(32'h38373635, 3'd4);
    repeat (4) cyc();
    check("latency_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'h34333231);
      check("bp_rinc", rinc, 0);
      check("bp_fifo_level", fifo_q.size(), 4);
    end
    out_ready = 1'b1;
    drain("backpressure", 20);
    check("bp_wcnt", word_cnt, 5);

    // Flush coinciding with the third pop
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    fifo_q.push_back(8'hA3);
    push_exp(32'h00A3A2A1, 3'd3);
    repeat (2) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_pop_bytes", out_bytes, 3);
    drain("flush_pop", 10);
    check("flush_pop_wcnt", word_cnt, 6);

    // Reset mid-word discards the partial bytes
    fifo_q.push_back(8'h41);
    fifo_q.push_back(8'h42);
    repeat (2) cyc();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h21 + 8'(i));
    #2;
    rrst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_bytes", out_bytes, 0);
    check("mid_rst_wcnt", word_cnt, 0);
    check("mid_rst_rinc", rinc, 0);
    exp_wc = 0;
    stall_prev = 1'b0;
    cyc();
    check("rst_no_pop", fifo_q.size(), 4);
    check("rst_no_valid", out_valid, 0);
    rrst_n = 1'b1;
    push_exp(32'h24232221, 3'd4);
    drain("after_reset", 20);
    check("after_reset_wcnt", word_cnt, 1);

    // Single byte left with the FIFO empty
    fifo_q.push_back(8'h5A);
    cyc();
`ifdef PACK_TIMEOUT_EN
    repeat (TIMEOUT_CYC - 1) cyc();
    check("timeout_not_early", out_valid, 0);
    push_exp(32'h0000005A, 3'd1);
    cyc();
    check("timeout_valid", out_valid, 1);
    check("timeout_data", out_data, 32'h0000005A);
    check("timeout_bytes", out_bytes, 1);
    drain("timeout", 10);
`else
    repeat (TIMEOUT_CYC + 4) cyc();
    check("no_autoflush", out_valid, 0);
    push_exp(32'h0000005A, 3'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain("lone_byte", 10);
`endif
    check("lone_wcnt", word_cnt, 16'(exp_wc));

    // Random stream: gaps in the FIFO and random backpressure
    pend_word = '0;
    pend_n = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [7:0] b;
        b = 8'($urandom);
        fifo_q.push_back(b);
        pend_word = pend_word | (32'(b) << (8 * pend_n));
        pend_n++;
        if (pend_n == LANES) begin
          push_exp(pend_word, 3'(LANES));
          pend_word = '0;
          pend_n = 0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    out_ready = 1'b1;
    drain("random", 1000);
    repeat (2) cyc();
    if (pend_n != 0) begin
      push_exp(pend_word, 3'(pend_n));
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drain("random_tail", 10);
    end
    check("random_wcnt", word_cnt, 16'(exp_wc));
    check("random_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
